// File: rtl/mem_rmw_ctrl.sv
// Bridges MEM-stage byte/half/word loads and stores onto a word-only data memory.
// Sub-word stores run as read-modify-write; loads are lane-selected and extended.
//
// state | meaning
// IDLE  | waiting for req_valid; request latched and checked on accept
// ACC   | DM read; load capture, word store write, or merge capture
// WR    | write merged word for a byte/half store
// RESP  | one-cycle result: rdata_valid, err, or plain store completion
module mem_rmw_ctrl #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic [31:0] dm_add,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  output logic        dm_we,
  output logic        dm_re,
  input  logic [31:0] dm_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic        bad_q, bad_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;

  logic        bad_req;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        word_store_acc;

  always_comb begin
    bad_req = (req_size == SZ_BAD)
           || (req_size == SZ_HALF && req_addr[0])
           || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
           || (req_addr >= ADDR_LIMIT);
  end

  always_comb begin
    lane_b = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = dm_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: load_ext = {{24{sign_q & lane_b[7]}}, lane_b};
      SZ_HALF: load_ext = {{16{sign_q & lane_h[15]}}, lane_h};
      default: load_ext = dm_rdata;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (size_q == SZ_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    bad_d   = bad_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sign_d  = req_sign;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          pc_d    = req_pc;
          bad_d   = bad_req;
          if (bad_req) begin
            state_d = S_RESP;
            if (!req_we) rdata_d = 32'h0;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (!we_q) begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end else if (size_q == SZ_WORD) begin
          state_d = S_RESP;
        end else begin
          merge_d = dm_rdata;
          state_d = S_WR;
        end
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      pc_q    <= 32'h0;
      bad_q   <= 1'b0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

  // Write strobes come only from registered state, so an async reset kills them at once.
  always_comb begin
    word_store_acc = (state_q == S_ACC) && we_q && (size_q == SZ_WORD);
    dm_we       = word_store_acc || (state_q == S_WR);
    dm_wd       = (state_q == S_WR) ? merged : (word_store_acc ? wdata_q : 32'h0);
    dm_re       = (state_q == S_ACC);
    dm_add      = {addr_q[31:2], 2'b00};
    dm_pc       = pc_q;
    stall       = reset && (((state_q != S_IDLE) && (state_q != S_RESP))
                            || ((state_q == S_IDLE) && req_valid));
    rdata       = rdata_q;
    rdata_valid = (state_q == S_RESP) && !bad_q && !we_q;
    err         = (state_q == S_RESP) && bad_q;
  end

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Bench for mem_rmw_ctrl: word-array DM model, directed cases and a random op stream
// checked against an arithmetic reference of memory and load results.
module tb_mem_rmw_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;
  logic [31:0] dm_add;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic        dm_we;
  logic        dm_re;
  logic [31:0] dm_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] dm_mem  [0:3071];
  logic [31:0] ref_mem [0:3071];
  logic        dm_clr;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  mem_rmw_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .err(err), .dm_add(dm_add), .dm_wd(dm_wd),
    .dm_pc(dm_pc), .dm_we(dm_we), .dm_re(dm_re), .dm_rdata(dm_rdata)
  );

  assign dm_rdata = (dm_add < 32'h3000) ? dm_mem[dm_add[13:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (dm_clr) begin
      for (int i = 0; i < 3072; i++) dm_mem[i] <= 32'h0;
    end else if (dm_we && dm_add < 32'h3000) begin
      dm_mem[dm_add[13:2]] <= dm_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic sign, input logic [31:0] addr);
    logic [31:0] v;
    if (size == 2'b00) begin
      v = (w >> (8 * addr[1:0])) & 32'hFF;
      if (sign && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = (w >> (16 * addr[1])) & 32'hFFFF;
      if (sign && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (size == 2'b10) return d;
    sh   = (size == 2'b00) ? 8 * addr[1:0] : 16 * addr[1];
    mask = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic do_op(input string tag, input logic we, input logic [1:0] size,
                       input logic sign, input logic [31:0] addr, input logic [31:0] wdata);
    logic        bad;
    logic [31:0] exp_rd;
    int          exp_cyc, exp_we, nst, nwe, idx;
    logic        done;
    logic [31:0] pc;
    bad = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'h3000);
    idx = int'(addr[13:2]);
    exp_cyc = bad ? 1 : ((we && size != 2'b10) ? 3 : 2);
    exp_we  = (!bad && we) ? 1 : 0;
    if (!we) begin
      exp_rd = bad ? 32'h0 : model_load(ref_mem[idx], size, sign, addr);
      last_rdata = exp_rd;
    end else begin
      exp_rd = last_rdata;
      if (!bad) ref_mem[idx] = model_store(ref_mem[idx], size, addr, wdata);
    end
    pc = $urandom;
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata; req_pc = pc;
    nst = 0; nwe = 0; done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (dm_we) nwe++;
      if (c == 1 && !bad) begin
        chk({tag, "_dm_add"}, dm_add, {addr[31:2], 2'b00});
        chk({tag, "_dm_pc"}, dm_pc, pc);
      end
      if (stall) nst++;
      else begin
        done = 1'b1;
        chk({tag, "_rvalid"}, 32'(rdata_valid), 32'(!we && !bad));
        chk({tag, "_err"}, 32'(err), 32'(bad));
        chk({tag, "_rdata"}, rdata, exp_rd);
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_stall_cyc"}, 32'(nst), 32'(exp_cyc));
    chk({tag, "_we_cyc"}, 32'(nwe), 32'(exp_we));
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (we && addr < 32'h3000) chk({tag, "_mem"}, dm_mem[idx], ref_mem[idx]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_rvalid"}, 32'(rdata_valid), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_dm_add"}, dm_add, 32'h0);
    chk({tag, "_dm_wd"}, dm_wd, 32'h0);
    chk({tag, "_dm_pc"}, dm_pc, 32'h0);
    chk({tag, "_dm_we"}, 32'(dm_we), 32'd0);
    chk({tag, "_dm_re"}, 32'(dm_re), 32'd0);
  endtask

  initial begin
    reset = 1'b0; dm_clr = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_sign = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    last_rdata = 32'h0;
    for (int i = 0; i < 3072; i++) ref_mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    dm_clr = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Read-modify-write into a freshly written word.
    do_op("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    do_op("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
    chk("word10", dm_mem[4], 32'h1122_AA44);

    do_op("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h8000_FF7F);
    do_op("lb20", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
    chk("lb20_abs", rdata, 32'h0000_007F);
    do_op("lb21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    chk("lb21_abs", rdata, 32'hFFFF_FFFF);
    do_op("lhu22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    chk("lhu22_abs", rdata, 32'h0000_8000);
    do_op("lh22", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    chk("lh22_abs", rdata, 32'hFFFF_8000);

    do_op("sw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h0123_4567);
    do_op("sh32", 1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_BEEF);
    chk("word30", dm_mem[12], 32'hBEEF_4567);

    do_op("lh21_err", 1'b0, 2'b01, 1'b1, 32'h21, 32'h0);
    do_op("sw2_err", 1'b1, 2'b10, 1'b0, 32'h2, 32'h5555_5555);
    do_op("lw3000_err", 1'b0, 2'b10, 1'b0, 32'h3000, 32'h0);
    do_op("lw2ffc", 1'b0, 2'b10, 1'b0, 32'h2FFC, 32'h0);
    do_op("sz11_err", 1'b1, 2'b11, 1'b0, 32'h40, 32'h1);

    // Reset while the sub-word store sits in WR: no write may land.
    do_op("sw40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_sign = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h0000_0011; req_pc = 32'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wr_state_we", 32'(dm_we), 32'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("rst_wr");
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("word40", dm_mem[16], 32'hCAFE_F00D);
    reset = 1'b1;
    last_rdata = 32'h0;
    @(posedge clk); #1;

    // Back-to-back stream, then random mix.
    do_op("b2b_lw", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    do_op("b2b_sw", 1'b1, 2'b10, 1'b0, 32'h44, 32'h89AB_CDEF);
    do_op("b2b_lb", 1'b0, 2'b00, 1'b1, 32'h47, 32'h0);
    do_op("b2b_sb", 1'b1, 2'b00, 1'b0, 32'h45, 32'h0000_0077);
    do_op("b2b_lw2", 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);

    for (int i = 0; i < 120; i++) begin
      logic [31:0] a;
      if ($urandom % 10 == 0) a = 32'h3000 + ($urandom % 64);
      else a = $urandom % 256;
      do_op("rnd", 1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
